// File: rtl/piso_pkg.sv
// Shared defaults and helpers for the PISO LED shifter and its prescaler.
package piso_pkg;

    localparam int unsigned DefaultWidth   = 4;
    localparam int unsigned DefaultTickDiv = 1;

    // Enough bits to hold every count from 0 up to and including width.
    function automatic int unsigned bits_left_width(input int unsigned width);
        return int'($clog2(width + 1));
    endfunction

endpackage

// File: rtl/piso_tick_gen.sv
// Shift-tick prescaler: one-cycle tick every TICK_DIV clocks, restartable from zero.
module piso_tick_gen
    import piso_pkg::*;
#(
    parameter int unsigned TICK_DIV = DefaultTickDiv
) (
    input  logic clk,
    input  logic clear,
    input  logic restart,
    output logic tick
);

    // A divide-by-one counter still needs one bit; it simply never leaves zero.
    localparam int unsigned CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] count_q, count_d;

    assign tick = (count_q == LastCnt);

    always_comb begin
        count_d = count_q + CntW'(1);
        if (restart || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_led_shifter.sv
// Parallel-in/serial-out shift register mirrored onto LEDs, with a bit counter
// tracking how many loaded bits are still waiting to be shifted out.
module piso_led_shifter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned TICK_DIV  = DefaultTickDiv,
    parameter logic        FILL_BIT  = 1'b0
) (
    input  logic                                clk,
    input  logic                                clear,
    input  logic                                load,
    input  logic [WIDTH-1:0]                    parallel_in,
    output logic                                serial_out,
    output logic [WIDTH-1:0]                    leds,
    output logic                                busy,
    output logic                                done,
    output logic [bits_left_width(WIDTH)-1:0]   bits_left
);

    localparam int unsigned BlW = bits_left_width(WIDTH);
    localparam logic [BlW-1:0] FullCount = BlW'(WIDTH);
    localparam logic [BlW-1:0] OneLeft   = BlW'(1);

    logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
    logic [BlW-1:0]   bits_q, bits_d;
    logic             done_q, done_d;
    logic             tick;

    piso_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .clear   (clear),
        .restart (load),
        .tick    (tick)
    );

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shreg_q[WIDTH-2:0], FILL_BIT};
        end else begin
            shifted = {FILL_BIT, shreg_q[WIDTH-1:1]};
        end
    end

    // Load beats a coincident tick, so a reload on the final tick never pulses done.
    always_comb begin
        shreg_d = shreg_q;
        bits_d  = bits_q;
        done_d  = 1'b0;
        if (load) begin
            shreg_d = parallel_in;
            bits_d  = FullCount;
        end else if (tick) begin
            shreg_d = shifted;
            if (bits_q != '0) begin
                bits_d = bits_q - OneLeft;
            end
            done_d = (bits_q == OneLeft);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            shreg_q <= '0;
            bits_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            bits_q  <= bits_d;
            done_q  <= done_d;
        end
    end

    assign serial_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign leds       = shreg_q;
    assign busy       = (bits_q != '0);
    assign done       = done_q;
    assign bits_left  = bits_q;

endmodule

// File: tb/tb_piso_led_shifter.sv
// Vector-table and scoreboard bench for piso_led_shifter and two parameter variants.
module tb_piso_led_shifter;

    typedef struct {
        int         sel;      // 0 = default, 1 = MSB_FIRST, 2 = TICK_DIV=3
        logic       clr;
        logic       ld;
        logic [3:0] pin;
        logic [3:0] leds;
        logic       ser;
        logic       busy;
        logic       done;
        logic [2:0] bits;
    } vec_t;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       load = 1'b0;
    logic [3:0] parallel_in = 4'h0;

    logic       ser0, ser1, ser2;
    logic [3:0] leds0, leds1, leds2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [2:0] bits0, bits1, bits2;

    int n_vec = 0;
    int n_bad = 0;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    piso_led_shifter dut (
        .clk (clk), .clear (clear), .load (load), .parallel_in (parallel_in),
        .serial_out (ser0), .leds (leds0), .busy (busy0), .done (done0), .bits_left (bits0)
    );

    piso_led_shifter #(.MSB_FIRST (1'b1)) dut_msb (
        .clk (clk), .clear (clear), .load (load), .parallel_in (parallel_in),
        .serial_out (ser1), .leds (leds1), .busy (busy1), .done (done1), .bits_left (bits1)
    );

    piso_led_shifter #(.TICK_DIV (3)) dut_div (
        .clk (clk), .clear (clear), .load (load), .parallel_in (parallel_in),
        .serial_out (ser2), .leds (leds2), .busy (busy2), .done (done2), .bits_left (bits2)
    );

    function automatic vec_t mk(input int sel, input logic clr, input logic ld,
                                input logic [3:0] pin, input logic [3:0] leds,
                                input logic ser, input logic busy, input logic done,
                                input logic [2:0] bits);
        vec_t v;
        v.sel = sel; v.clr = clr; v.ld = ld; v.pin = pin; v.leds = leds;
        v.ser = ser; v.busy = busy; v.done = done; v.bits = bits;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare just after the edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        logic [9:0] got, want;
        clear       = v.clr;
        load        = v.ld;
        parallel_in = v.pin;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        case (e.sel)
            1:       got = {leds1, ser1, busy1, done1, bits1};
            2:       got = {leds2, ser2, busy2, done2, bits2};
            default: got = {leds0, ser0, busy0, done0, bits0};
        endcase
        want = {e.leds, e.ser, e.busy, e.done, e.bits};
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got leds=%b ser=%b busy=%b done=%b bits=%0d, want leds=%b ser=%b busy=%b done=%b bits=%0d",
                     tag, got[9:6], got[5], got[4], got[3], got[2:0],
                     want[9:6], want[5], want[4], want[3], want[2:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset holds everything low even with load asserted.
        tbl.push_back(mk(0, 1, 1, 4'hF, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 4'hF, 4'h0, 0, 0, 0, 0));
        // LSB-first shift of 0101.
        tbl.push_back(mk(0, 0, 1, 4'h5, 4'h5, 1, 1, 0, 4));
        tbl.push_back(mk(0, 0, 1, 4'h5, 4'h5, 1, 1, 0, 4));
        tbl.push_back(mk(0, 0, 1, 4'h5, 4'h5, 1, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 4'h5, 4'h2, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 4'h5, 4'h1, 1, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 4'h5, 4'h0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'h5, 4'h0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 4'h5, 4'h0, 0, 0, 0, 0));
        // Reload after one shift.
        tbl.push_back(mk(0, 0, 1, 4'h5, 4'h5, 1, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 4'h5, 4'h2, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 1, 4'h8, 4'h8, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 4'h8, 4'h4, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 4'h8, 4'h2, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 4'h8, 4'h1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'h8, 4'h0, 0, 0, 1, 0));
        // Load tracking: inputs follow one cycle later, no shifting.
        tbl.push_back(mk(0, 0, 1, 4'h8, 4'h8, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 1, 4'hC, 4'hC, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 1, 4'hC, 4'hC, 0, 1, 0, 4));
        // Load on the final tick wins and suppresses done.
        tbl.push_back(mk(0, 0, 1, 4'h1, 4'h1, 1, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 4'h1, 4'h0, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 4'h1, 4'h0, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 4'h1, 4'h0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 4'h3, 4'h3, 1, 1, 0, 4));
        // Clear during the second shift aborts without done.
        tbl.push_back(mk(0, 0, 0, 4'h3, 4'h1, 1, 1, 0, 3));
        tbl.push_back(mk(0, 1, 0, 4'h3, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'h3, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'h3, 4'h0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // MSB-first variant: serial order 0,1,0,1.
        apply(mk(1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0), "msb_clear");
        apply(mk(1, 0, 1, 4'h5, 4'h5, 0, 1, 0, 4), "msb_load");
        apply(mk(1, 0, 0, 4'h5, 4'hA, 1, 1, 0, 3), "msb_sh1");
        apply(mk(1, 0, 0, 4'h5, 4'h4, 0, 1, 0, 2), "msb_sh2");
        apply(mk(1, 0, 0, 4'h5, 4'h8, 1, 1, 0, 1), "msb_sh3");
        apply(mk(1, 0, 0, 4'h5, 4'h0, 0, 0, 1, 0), "msb_sh4");

        // Divide-by-3 variant: shift on every third edge after release, done on edge 12.
        apply(mk(2, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0), "div_clear");
        apply(mk(2, 0, 1, 4'h5, 4'h5, 1, 1, 0, 4), "div_load");
        for (int e = 1; e <= 13; e++) begin
            int         ns;
            logic [3:0] lv;
            ns = (e / 3 > 4) ? 4 : e / 3;
            lv = 4'h5 >> ns;
            apply(mk(2, 0, 0, 4'h5, lv, lv[0], (ns < 4), (e == 12), 3'(4 - ns)),
                  $sformatf("div_e%0d", e));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
